// File: rtl/cpu_ce_pkg.sv
// Shared types and helpers for the CPU/bus clock-enable generator.
package cpu_ce_pkg;

  // Widest period field the clamp helper accepts.
  localparam int unsigned MAX_DIV_W = 16;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    QUIET
  } ce_state_t;

  // Periods of 0 or 1 cannot hold both phases; force a minimum of 2.
  function automatic logic [MAX_DIV_W-1:0] clamp_period(input logic [MAX_DIV_W-1:0] field);
    return (field < MAX_DIV_W'(2)) ? MAX_DIV_W'(2) : field;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Phase counter with p/n enable pulses, reloadable period, hold and stall gating.
module ce_divider
  import cpu_ce_pkg::*;
#(
  parameter int unsigned DIV_W = 6
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] period,
  input  logic             load,
  input  logic             hold,
  input  logic             stall,
  output logic             ce_p,
  output logic             ce_n,
  output logic             wrap_c
);

  logic [DIV_W-1:0] ph;
  logic [DIV_W-1:0] cur_per;
  logic [DIV_W-1:0] per_in;
  logic [DIV_W-1:0] per_eff;
  logic [DIV_W-1:0] half;
  logic             loaded;
  logic             en;

  // Until the first reload the live period input stands in for cur_per.
  assign per_in  = DIV_W'(clamp_period(MAX_DIV_W'(period)));
  assign per_eff = loaded ? cur_per : per_in;
  assign half    = per_eff >> 1;
  assign wrap_c  = (ph == per_eff - DIV_W'(1));

  // Phase count, period reload at the T-state boundary, and pulse generation.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ph      <= '0;
      cur_per <= '0;
      loaded  <= 1'b0;
      en      <= 1'b0;
      ce_p    <= 1'b0;
      ce_n    <= 1'b0;
    end else if (hold) begin
      ph   <= '0;
      en   <= 1'b0;
      ce_p <= 1'b0;
      ce_n <= 1'b0;
      if (load) begin
        cur_per <= per_in;
        loaded  <= 1'b1;
      end
    end else begin
      ce_p <= (ph == '0) & ~stall;
      ce_n <= (ph == half) & en;
      if (ph == '0) en <= ~stall;
      if (wrap_c) begin
        ph      <= '0;
        cur_per <= per_in;
        loaded  <= 1'b1;
      end else begin
        ph <= ph + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_ce_gen.sv
// CPU T-state and bus enable generator with programmable speed modes and glitch-free switching.
module cpu_ce_gen
  import cpu_ce_pkg::*;
#(
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned DIV_W     = 6,
  parameter int unsigned GAP       = 32,
  parameter int unsigned BUS_DIV   = 16,
  parameter int unsigned MW        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                       clk_sys,
  input  logic                       rst_n,
  input  logic [NUM_MODES*DIV_W-1:0] periods,
  input  logic [MW-1:0]              mode_sel,
  input  logic                       stall,
  output logic                       ce_p,
  output logic                       ce_n,
  output logic                       ce_bus_p,
  output logic                       ce_bus_n,
  output logic [MW-1:0]              mode_active,
  output logic                       switching
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  ce_state_t        state;
  ce_state_t        state_nxt;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_nxt;
  logic [MW-1:0]    mode_nxt;
  logic [MW-1:0]    per_mode_c;
  logic             sel_valid_c;
  logic             hold_c;
  logic             load_c;
  logic             cpu_wrap_c;
  logic             bus_wrap_unused;
  logic [DIV_W-1:0] cpu_period_c;

  // Select the period field of mode idx; out-of-range indices read zero.
  function automatic logic [DIV_W-1:0] field_of(input logic [NUM_MODES*DIV_W-1:0] flds,
                                                input logic [MW-1:0]              idx);
    field_of = '0;
    for (int unsigned k = 0; k < NUM_MODES; k++) begin
      if (idx == MW'(k)) field_of = flds[k*DIV_W +: DIV_W];
    end
  endfunction

  assign sel_valid_c  = (32'(mode_sel) < NUM_MODES);
  // At QUIET exit the divider loads the incoming mode's period; otherwise the active one.
  assign per_mode_c   = ((state == QUIET) && sel_valid_c) ? mode_sel : mode_active;
  assign cpu_period_c = field_of(periods, per_mode_c);

  // Mode-switch sequencing: finish the T-state in flight, stay silent for GAP cycles, then adopt mode_sel.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap;
    mode_nxt  = mode_active;
    hold_c    = 1'b0;
    load_c    = 1'b0;
    unique case (state)
      RUN: begin
        if (sel_valid_c && (mode_sel != mode_active)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cpu_wrap_c) begin
          state_nxt = QUIET;
          gap_nxt   = GAP_W'(GAP - 1);
        end
      end
      QUIET: begin
        hold_c = 1'b1;
        if (gap == '0) begin
          state_nxt = RUN;
          load_c    = 1'b1;
          if (sel_valid_c) mode_nxt = mode_sel;
        end else begin
          gap_nxt = gap - GAP_W'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state, gap counter and registered status outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      gap         <= '0;
      mode_active <= '0;
      switching   <= 1'b0;
    end else begin
      state       <= state_nxt;
      gap         <= gap_nxt;
      mode_active <= mode_nxt;
      switching   <= (state_nxt != RUN);
    end
  end

  ce_divider #(
    .DIV_W(DIV_W)
  ) u_cpu_div (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .period (cpu_period_c),
    .load   (load_c),
    .hold   (hold_c),
    .stall  (stall),
    .ce_p   (ce_p),
    .ce_n   (ce_n),
    .wrap_c (cpu_wrap_c)
  );

  ce_divider #(
    .DIV_W(DIV_W)
  ) u_bus_div (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .period (DIV_W'(BUS_DIV)),
    .load   (1'b0),
    .hold   (1'b0),
    .stall  (1'b0),
    .ce_p   (ce_bus_p),
    .ce_n   (ce_bus_n),
    .wrap_c (bus_wrap_unused)
  );

endmodule
